// File: rtl/mul_err_stats.sv
// mul_err_stats: three-stage error-statistics collector for an 8x8 multiplier
// under test. Stage 1 captures the operands and the product under test. Stage 2
// computes the exact product and the absolute error. Stage 3 accumulates over
// windows of 2^WINDOW_LOG2 samples and publishes the sum, maximum, nonzero
// count and mean of the error at the end of each window.
// Optional feature macro: MUL_ERR_BIAS_EN adds a signed bias accumulator that
// drives err_bias. When the macro is not defined, err_bias is tied to zero.
module mul_err_stats #(
    parameter int DATA_WIDTH  = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int WINDOW_LOG2 = 10,
    parameter int ACC_WIDTH   = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_a,
    input  logic [DATA_WIDTH-1:0]  in_b,
    input  logic [OUT_WIDTH-1:0]   in_mul,
    output logic                   out_valid,
    output logic [ACC_WIDTH-1:0]   err_sum,
    output logic [OUT_WIDTH-1:0]   err_max,
    output logic [WINDOW_LOG2:0]   err_cnt,
    output logic [OUT_WIDTH-1:0]   err_mean,
    output logic [ACC_WIDTH-1:0]   err_bias,
    output logic                   busy
);

    // The accumulator width must hold a full window of worst-case errors,
    // and the product width must be exactly twice the operand width.
    if ((OUT_WIDTH != 2 * DATA_WIDTH) || (ACC_WIDTH < OUT_WIDTH + WINDOW_LOG2 + 1)) begin : g_param_check
        $fatal(1, "mul_err_stats: illegal parameter combination");
    end

    localparam logic [WINDOW_LOG2-1:0] SCNT_LAST = {WINDOW_LOG2{1'b1}};

    logic                   v1_q, v1_d, v2_q, v2_d, nz2_q, nz2_d;
    logic [DATA_WIDTH-1:0]  a1_q, a1_d, b1_q, b1_d;
    logic [OUT_WIDTH-1:0]   mul1_q, mul1_d, d2_q, d2_d, exact_s;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d, acc_sum_s, mean_full_s;
    logic [OUT_WIDTH-1:0]   mx_q, mx_d, mx_new_s;
    logic [WINDOW_LOG2:0]   nzc_q, nzc_d, nzc_new_s;
    logic [WINDOW_LOG2-1:0] scnt_q, scnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]   err_sum_q, err_sum_d;
    logic [OUT_WIDTH-1:0]   err_max_q, err_max_d, err_mean_q, err_mean_d;
    logic [WINDOW_LOG2:0]   err_cnt_q, err_cnt_d;
    logic                   last_s;

    // The window closes when the sample in stage 3 is the last one of its window.
    assign last_s = v2_q && (scnt_q == SCNT_LAST);

    // Stages 1 and 2: capture the inputs, then form the exact product and |error|.
    always_comb begin
        v1_d    = in_valid;
        a1_d    = in_a;
        b1_d    = in_b;
        mul1_d  = in_mul;
        exact_s = OUT_WIDTH'(a1_q) * OUT_WIDTH'(b1_q);
        if (exact_s >= mul1_q) begin
            d2_d = exact_s - mul1_q;
        end else begin
            d2_d = mul1_q - exact_s;
        end
        v2_d  = v1_q;
        nz2_d = (d2_d != {OUT_WIDTH{1'b0}});
    end

    // Stage 3: accumulate the window, and publish and restart on its last sample.
    always_comb begin
        acc_sum_s   = acc_q + {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, d2_q};
        mx_new_s    = (d2_q > mx_q) ? d2_q : mx_q;
        nzc_new_s   = nzc_q + {{WINDOW_LOG2{1'b0}}, nz2_q};
        mean_full_s = acc_sum_s >> WINDOW_LOG2;
        acc_d       = acc_q;
        mx_d        = mx_q;
        nzc_d       = nzc_q;
        scnt_d      = scnt_q;
        out_valid_d = 1'b0;
        err_sum_d   = err_sum_q;
        err_max_d   = err_max_q;
        err_cnt_d   = err_cnt_q;
        err_mean_d  = err_mean_q;
        if (last_s) begin
            err_sum_d   = acc_sum_s;
            err_max_d   = mx_new_s;
            err_cnt_d   = nzc_new_s;
            err_mean_d  = mean_full_s[OUT_WIDTH-1:0];
            out_valid_d = 1'b1;
            acc_d       = {ACC_WIDTH{1'b0}};
            mx_d        = {OUT_WIDTH{1'b0}};
            nzc_d       = {(WINDOW_LOG2+1){1'b0}};
            scnt_d      = {WINDOW_LOG2{1'b0}};
        end else if (v2_q) begin
            acc_d  = acc_sum_s;
            mx_d   = mx_new_s;
            nzc_d  = nzc_new_s;
            scnt_d = scnt_q + WINDOW_LOG2'(1);
        end else begin
            scnt_d = scnt_q;
        end
    end

    // Pipeline and statistics registers; reset clears everything, while clear
    // flushes the pipeline and partial window but keeps the published results.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            a1_q        <= {DATA_WIDTH{1'b0}};
            b1_q        <= {DATA_WIDTH{1'b0}};
            mul1_q      <= {OUT_WIDTH{1'b0}};
            v2_q        <= 1'b0;
            d2_q        <= {OUT_WIDTH{1'b0}};
            nz2_q       <= 1'b0;
            acc_q       <= {ACC_WIDTH{1'b0}};
            mx_q        <= {OUT_WIDTH{1'b0}};
            nzc_q       <= {(WINDOW_LOG2+1){1'b0}};
            scnt_q      <= {WINDOW_LOG2{1'b0}};
            out_valid_q <= 1'b0;
            err_sum_q   <= {ACC_WIDTH{1'b0}};
            err_max_q   <= {OUT_WIDTH{1'b0}};
            err_cnt_q   <= {(WINDOW_LOG2+1){1'b0}};
            err_mean_q  <= {OUT_WIDTH{1'b0}};
        end else if (clear) begin
            v1_q        <= 1'b0;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            mul1_q      <= mul1_d;
            v2_q        <= 1'b0;
            d2_q        <= d2_d;
            nz2_q       <= nz2_d;
            acc_q       <= {ACC_WIDTH{1'b0}};
            mx_q        <= {OUT_WIDTH{1'b0}};
            nzc_q       <= {(WINDOW_LOG2+1){1'b0}};
            scnt_q      <= {WINDOW_LOG2{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            mul1_q      <= mul1_d;
            v2_q        <= v2_d;
            d2_q        <= d2_d;
            nz2_q       <= nz2_d;
            acc_q       <= acc_d;
            mx_q        <= mx_d;
            nzc_q       <= nzc_d;
            scnt_q      <= scnt_d;
            out_valid_q <= out_valid_d;
            err_sum_q   <= err_sum_d;
            err_max_q   <= err_max_d;
            err_cnt_q   <= err_cnt_d;
            err_mean_q  <= err_mean_d;
        end
    end

`ifdef MUL_ERR_BIAS_EN
    logic [OUT_WIDTH:0]   bias2_q, bias2_d;
    logic [ACC_WIDTH-1:0] bacc_q, bacc_d, bacc_sum_s, err_bias_q, err_bias_d;

    // Signed bias path: per-sample (in_mul - exact), sign-extended and accumulated.
    always_comb begin
        bias2_d    = {1'b0, mul1_q} - {1'b0, exact_s};
        bacc_sum_s = bacc_q + {{(ACC_WIDTH-OUT_WIDTH-1){bias2_q[OUT_WIDTH]}}, bias2_q};
        bacc_d     = bacc_q;
        err_bias_d = err_bias_q;
        if (last_s) begin
            err_bias_d = bacc_sum_s;
            bacc_d     = {ACC_WIDTH{1'b0}};
        end else if (v2_q) begin
            bacc_d = bacc_sum_s;
        end else begin
            bacc_d = bacc_q;
        end
    end

    // Bias registers follow the same reset/clear rules as the error accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            bias2_q    <= {(OUT_WIDTH+1){1'b0}};
            bacc_q     <= {ACC_WIDTH{1'b0}};
            err_bias_q <= {ACC_WIDTH{1'b0}};
        end else if (clear) begin
            bias2_q    <= bias2_d;
            bacc_q     <= {ACC_WIDTH{1'b0}};
        end else begin
            bias2_q    <= bias2_d;
            bacc_q     <= bacc_d;
            err_bias_q <= err_bias_d;
        end
    end

    assign err_bias = err_bias_q;
`else
    assign err_bias = {ACC_WIDTH{1'b0}};
`endif

    assign out_valid = out_valid_q;
    assign err_sum   = err_sum_q;
    assign err_max   = err_max_q;
    assign err_cnt   = err_cnt_q;
    assign err_mean  = err_mean_q;
    assign busy      = v1_q | v2_q | (scnt_q != {WINDOW_LOG2{1'b0}});

endmodule

// File: tb/tb_mul_err_stats.sv
// Directed testbench for mul_err_stats: a default-parameter instance (1024-sample
// windows) and a WINDOW_LOG2=2 instance (4-sample windows) on a shared clock.
module tb_mul_err_stats;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-parameter instance.
    logic        b_clear, b_in_valid, b_out_valid, b_busy;
    logic [7:0]  b_a, b_b;
    logic [15:0] b_mul, b_err_max, b_err_mean;
    logic [39:0] b_err_sum, b_err_bias;
    logic [10:0] b_err_cnt;

    // Small-window instance.
    logic        s_clear, s_in_valid, s_out_valid, s_busy;
    logic [7:0]  s_a, s_b;
    logic [15:0] s_mul, s_err_max, s_err_mean;
    logic [39:0] s_err_sum, s_err_bias;
    logic [2:0]  s_err_cnt;

    mul_err_stats u_big (
        .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_in_valid),
        .in_a(b_a), .in_b(b_b), .in_mul(b_mul), .out_valid(b_out_valid),
        .err_sum(b_err_sum), .err_max(b_err_max), .err_cnt(b_err_cnt),
        .err_mean(b_err_mean), .err_bias(b_err_bias), .busy(b_busy)
    );

    mul_err_stats #(.WINDOW_LOG2(2)) u_small (
        .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid),
        .in_a(s_a), .in_b(s_b), .in_mul(s_mul), .out_valid(s_out_valid),
        .err_sum(s_err_sum), .err_max(s_err_max), .err_cnt(s_err_cnt),
        .err_mean(s_err_mean), .err_bias(s_err_bias), .busy(s_busy)
    );

    int checks   = 0;
    int failures = 0;

    // Pulse monitors: count out_valid pulses and record cycle/err_sum of the small one.
    int cyc = 0;
    int b_npulse = 0;
    int s_npulse = 0;
    int s_pulse_t [0:63];
    logic [39:0] s_pulse_sum [0:63];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (b_out_valid === 1'b1) b_npulse = b_npulse + 1;
        if (s_out_valid === 1'b1) begin
            if (s_npulse < 64) begin
                s_pulse_t[s_npulse]   = cyc;
                s_pulse_sum[s_npulse] = s_err_sum;
            end
            s_npulse = s_npulse + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic s_drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [15:0] m);
        s_in_valid = v; s_a = a; s_b = b; s_mul = m;
        @(negedge clk);
    endtask

    logic [7:0]  ta, tb;
    logic [15:0] tm;
    logic [39:0] exp_bias;
    int base;

    initial begin
        rst = 1'b1;
        b_clear = 1'b0; b_in_valid = 1'b0; b_a = 8'd0; b_b = 8'd0; b_mul = 16'd0;
        s_clear = 1'b0; s_in_valid = 1'b0; s_a = 8'd0; s_b = 8'd0; s_mul = 16'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state of both instances.
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        chk("rst_b_err_sum",   64'(b_err_sum),   64'd0);
        chk("rst_b_err_max",   64'(b_err_max),   64'd0);
        chk("rst_b_err_cnt",   64'(b_err_cnt),   64'd0);
        chk("rst_b_err_mean",  64'(b_err_mean),  64'd0);
        chk("rst_b_err_bias",  64'(b_err_bias),  64'd0);
        chk("rst_b_busy",      64'(b_busy),      64'd0);
        chk("rst_s_busy",      64'(s_busy),      64'd0);

        // Test 1: exact products over a 1024-sample window.
        ta = 8'd11; tb = 8'd12;
        for (int i = 0; i < 1024; i++) begin
            b_in_valid = 1'b1; b_a = ta; b_b = tb; b_mul = 16'(ta) * 16'(tb);
            @(negedge clk);
            ta = ta + 8'd3; tb = tb + 8'd3;
        end
        b_in_valid = 1'b0;
        chk("t1_busy_inflight", 64'(b_busy), 64'd1);
        chk("t1_ov_t1", 64'(b_out_valid), 64'd0);
        @(negedge clk);
        chk("t1_ov_t2", 64'(b_out_valid), 64'd0);
        @(negedge clk);
        chk("t1_ov_t3",   64'(b_out_valid), 64'd1);
        chk("t1_err_sum", 64'(b_err_sum),   64'd0);
        chk("t1_err_max", 64'(b_err_max),   64'd0);
        chk("t1_err_cnt", 64'(b_err_cnt),   64'd0);
        chk("t1_err_mean",64'(b_err_mean),  64'd0);
        chk("t1_err_bias",64'(b_err_bias),  64'd0);
        @(negedge clk);
        chk("t1_ov_pulse", 64'(b_out_valid), 64'd0);
        #1;
        chk("t1_npulse", 64'(b_npulse), 64'd1);

        // Test 2: product off by +1 on every sample.
        ta = 8'd11; tb = 8'd12;
        for (int i = 0; i < 1024; i++) begin
            b_in_valid = 1'b1; b_a = ta; b_b = tb; b_mul = 16'(ta) * 16'(tb) + 16'd1;
            @(negedge clk);
            ta = ta + 8'd3; tb = tb + 8'd3;
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_ov",      64'(b_out_valid), 64'd1);
        chk("t2_err_sum", 64'(b_err_sum),   64'd1024);
        chk("t2_err_max", 64'(b_err_max),   64'd1);
        chk("t2_err_cnt", 64'(b_err_cnt),   64'd1024);
        chk("t2_err_mean",64'(b_err_mean),  64'd1);
`ifdef MUL_ERR_BIAS_EN
        chk("t2_err_bias",64'(b_err_bias),  64'd1024);
`else
        chk("t2_err_bias",64'(b_err_bias),  64'd0);
`endif

        // Test 3: one worst-case error followed by three exact samples.
        s_drive(1'b1, 8'd255, 8'd255, 16'd0);
        s_drive(1'b1, 8'd3,   8'd4,   16'd12);
        s_drive(1'b1, 8'd0,   8'd0,   16'd0);
        s_drive(1'b1, 8'd255, 8'd255, 16'd65025);
        s_in_valid = 1'b0;
        chk("t3_ov_t1", 64'(s_out_valid), 64'd0);
        @(negedge clk);
        chk("t3_ov_t2", 64'(s_out_valid), 64'd0);
        @(negedge clk);
        chk("t3_ov_t3",   64'(s_out_valid), 64'd1);
        chk("t3_err_sum", 64'(s_err_sum),   64'd65025);
        chk("t3_err_max", 64'(s_err_max),   64'd65025);
        chk("t3_err_cnt", 64'(s_err_cnt),   64'd1);
        chk("t3_err_mean",64'(s_err_mean),  64'd16256);
`ifdef MUL_ERR_BIAS_EN
        exp_bias = 40'd0 - 40'd65025;
`else
        exp_bias = 40'd0;
`endif
        chk("t3_err_bias",64'(s_err_bias),  64'(exp_bias));
        @(negedge clk);

        // Test 4: 12 back-to-back samples with error 2 give three pulses 4 cycles apart.
        #1;
        base = s_npulse;
        for (int i = 0; i < 12; i++) begin
            ta = 8'(i + 1);
            tm = 16'(ta) * 16'd3;
            if (i % 2 == 0) s_drive(1'b1, ta, 8'd3, tm - 16'd2);
            else            s_drive(1'b1, ta, 8'd3, tm + 16'd2);
        end
        s_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        #1;
        chk("t4_npulse", 64'(s_npulse - base), 64'd3);
        chk("t4_gap01", 64'(s_pulse_t[base+1] - s_pulse_t[base]),   64'd4);
        chk("t4_gap12", 64'(s_pulse_t[base+2] - s_pulse_t[base+1]), 64'd4);
        chk("t4_sum0", 64'(s_pulse_sum[base]),   64'd8);
        chk("t4_sum1", 64'(s_pulse_sum[base+1]), 64'd8);
        chk("t4_sum2", 64'(s_pulse_sum[base+2]), 64'd8);
        @(negedge clk);

        // Test 5: clear discards a partial window and the coincident sample.
        s_drive(1'b1, 8'd2, 8'd2, 16'd9);
        s_drive(1'b1, 8'd2, 8'd2, 16'd9);
        s_drive(1'b1, 8'd2, 8'd2, 16'd9);
        s_clear = 1'b1;
        s_drive(1'b1, 8'd2, 8'd2, 16'd9);
        s_clear = 1'b0;
        chk("t5_busy_after_clear", 64'(s_busy),      64'd0);
        chk("t5_ov_after_clear",   64'(s_out_valid), 64'd0);
        chk("t5_sum_held",         64'(s_err_sum),   64'd8);
        #1;
        base = s_npulse;
        s_drive(1'b1, 8'd1, 8'd1, 16'd0);
        s_drive(1'b1, 8'd1, 8'd1, 16'd0);
        s_drive(1'b1, 8'd1, 8'd1, 16'd0);
        s_drive(1'b1, 8'd1, 8'd1, 16'd0);
        s_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_ov",      64'(s_out_valid), 64'd1);
        chk("t5_err_sum", 64'(s_err_sum),   64'd4);
        chk("t5_err_cnt", 64'(s_err_cnt),   64'd4);
        chk("t5_err_max", 64'(s_err_max),   64'd1);
        #1;
        chk("t5_npulse", 64'(s_npulse - base), 64'd1);
        @(negedge clk);

        // Test 6: reset mid-window after a published window, then a fresh exact window.
        for (int i = 0; i < 4; i++) s_drive(1'b1, 8'd1, 8'd1, 16'd4);
        s_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_pre_sum", 64'(s_err_sum), 64'd12);
        s_drive(1'b1, 8'd5, 8'd6, 16'd30);
        s_drive(1'b1, 8'd7, 8'd8, 16'd50);
        s_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_ov",   64'(s_out_valid), 64'd0);
        chk("t6_rst_sum",  64'(s_err_sum),   64'd0);
        chk("t6_rst_max",  64'(s_err_max),   64'd0);
        chk("t6_rst_cnt",  64'(s_err_cnt),   64'd0);
        chk("t6_rst_mean", 64'(s_err_mean),  64'd0);
        chk("t6_rst_bias", 64'(s_err_bias),  64'd0);
        chk("t6_rst_busy", 64'(s_busy),      64'd0);
        s_drive(1'b1, 8'd9,  8'd9,  16'd81);
        s_drive(1'b1, 8'd10, 8'd20, 16'd200);
        s_drive(1'b1, 8'd0,  8'd77, 16'd0);
        s_drive(1'b1, 8'd128,8'd2,  16'd256);
        s_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_ov",       64'(s_out_valid), 64'd1);
        chk("t6_err_sum",  64'(s_err_sum),   64'd0);
        chk("t6_err_max",  64'(s_err_max),   64'd0);
        chk("t6_err_cnt",  64'(s_err_cnt),   64'd0);
        chk("t6_err_mean", 64'(s_err_mean),  64'd0);
        chk("t6_err_bias", 64'(s_err_bias),  64'd0);
        @(negedge clk);
        chk("t6_idle_busy", 64'(s_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_err_stats.md
# mul_err_stats

Pipelined error-statistics collector that sits directly downstream of the 8×8 `Mul` / SC multiplier under test. It captures each operand pair and the multiplier's product, computes the exact product internally, and accumulates absolute error over fixed windows of 2^WINDOW_LOG2 samples. At the end of each window it publishes sum, maximum, nonzero count and mean of the error. This is how the team scores approximate (stochastic) multipliers in simulation and on FPGA.

## Interface
- DATA_WIDTH, 8, operand width (unsigned)
- OUT_WIDTH, 16, product width; must equal 2*DATA_WIDTH
- WINDOW_LOG2, 10, window length N = 2^WINDOW_LOG2 samples
- ACC_WIDTH, 40, error accumulator width; must be ≥ OUT_WIDTH+WINDOW_LOG2+1
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- clear  input  1  synchronous flush of pipeline and partial window
- in_valid  input  1  sample present this cycle; no backpressure, accepted every cycle
- in_a  input  DATA_WIDTH  operand a (drives `io_inputs_1` of the multiplier)
- in_b  input  DATA_WIDTH  operand b (drives `io_inputs_0`)
- in_mul  input  OUT_WIDTH  product under test (`io_outs_0`), same cycle as operands
- out_valid  output  1  one-cycle pulse: window results updated
- err_sum  output  ACC_WIDTH  Σ|exact−in_mul| over last window
- err_max  output  OUT_WIDTH  max |exact−in_mul| over last window
- err_cnt  output  WINDOW_LOG2+1  samples with nonzero error in last window
- err_mean  output  OUT_WIDTH  err_sum >> WINDOW_LOG2, truncated
- err_bias  output  ACC_WIDTH  signed Σ(in_mul−exact), two's complement; see Configuration
- busy  output  1  partial window or in-flight sample present

## Operation
- Stage 1 (edge after in_valid): register a, b, mul, and v1=in_valid.
- Stage 2: exact = a1*b1 (unsigned, OUT_WIDTH bits, no truncation). d2 = |exact−mul1| (OUT_WIDTH bits). Register d2, v2, nz2=(d2≠0).
- Stage 3, when v2=1:
  - acc += d2; mx = max(mx, d2); nzc += nz2; scnt += 1.
  - If scnt == N−1 (last sample of window): publish err_sum=acc+d2, err_max=max(mx,d2), err_cnt=nzc+nz2, err_mean=(acc+d2)>>WINDOW_LOG2. Pulse out_valid. Zero acc, mx, nzc, scnt on the same edge, so the next window starts seamlessly.
- Published outputs hold until the next window completes.
- clear:
  - Zeroes v1, v2, acc, mx, nzc and scnt.
  - Does not alter published outputs; out_valid is forced to 0 that cycle.
  - A sample with in_valid in the same cycle as clear is discarded.
- busy = v1 | v2 | (scnt≠0).
- The ACC_WIDTH constraint guarantees no overflow; no saturation logic.
- Parameter violation: fatal in simulation via generate-time check.

## Timing
- Throughput: 1 sample/cycle, no bubbles required between windows.
- Latency: last sample of a window presented in cycle t → out_valid high in cycle t+3 only, with results valid in that cycle.
- Reset (rst=1 at an edge): every output is 0 (out_valid, err_sum, err_max, err_cnt, err_mean, err_bias, busy); all internal state is 0.
- rst has priority over clear. Reset mid-window discards everything.
- Operand/product wrap: inputs are treated modulo 2^DATA_WIDTH. No special handling.

## Configuration
- MUL_ERR_BIAS_EN defined: a signed bias accumulator runs alongside acc.
  - Per sample it adds the sign-extended (in_mul−exact).
  - Its value is published to err_bias at window end, and it is cleared with the other accumulators.
- Undefined: err_bias is tied to 0. No bias logic is synthesised.

## Test plan
- Exact product (in_mul=in_a*in_b), N=1024, a from 11 and b from 12, both +3 per cycle mod 256 → out_valid at t+3; err_sum=0, err_max=0, err_cnt=0, err_mean=0, err_bias=0.
- in_mul=exact+1 every sample, N=1024 → err_sum=1024, err_max=1, err_cnt=1024, err_mean=1; err_bias=+1024 (0 when MUL_ERR_BIAS_EN is undefined).
- WINDOW_LOG2=2; a=255, b=255, in_mul=0 once, then three exact samples → err_sum=65025, err_max=65025, err_cnt=1, err_mean=16256, err_bias=−65025.
- WINDOW_LOG2=2; 12 consecutive valid samples, each with error 2 → three out_valid pulses spaced exactly 4 cycles apart, each with err_sum=8.
- WINDOW_LOG2=2; 3 samples with error 5, then clear (with in_valid=1 in the same cycle), then 4 samples with error 1 → first out_valid shows err_sum=4, err_cnt=4; busy=0 the cycle after clear.
- rst asserted for 1 cycle mid-window after a published window → all outputs read 0 the next cycle; a fresh window of 4 exact samples yields all-zero stats.
